// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit: steps the servo through its positions, triggers one
// echo measurement per position and serialises an 8-character frame for each.
module sonar_sweep_uc #(
    parameter int TIMEOUT = 3_000_000,
    parameter int TW      = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       modo,
    input  logic       fim_distancia,
    input  logic       fim_transmissao,
    input  logic       fim_contador_serial,
    input  logic       fim_contador_intervalo,
    output logic       zera,
    output logic       zera_pwm,
    output logic       reset_updown,
    output logic       conta_updown,
    output logic       conta_intervalo,
    output logic       medir,
    output logic       conta_serial,
    output logic       transmitir,
    output logic       pronto,
    output logic       falha,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'b0000,
        PREPARACAO       = 4'b0001,
        ESPERA_INTERVALO = 4'b0010,
        MEDIDA           = 4'b0011,
        ESPERA_MEDIDA    = 4'b0100,
        TRANSMISSAO      = 4'b0101,
        ESPERA_TX        = 4'b0110,
        PROXIMO_CHAR     = 4'b0111,
        AJUSTA_SERVO     = 4'b1000,
        FINAL            = 4'b1001,
        ERRO             = 4'b1110
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          ligar_prev;
    logic          ligar_rise;
    logic          from_erro;
    logic [TW-1:0] watchdog;
    logic          wd_expired;

    assign ligar_rise = ligar & ~ligar_prev;
    assign wd_expired = (watchdog == TW'(TIMEOUT - 1));

    // from_erro remembers that AJUSTA_SERVO was reached without sending a
    // frame, so the serial index (still 0) must not be advanced there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INICIAL;
            ligar_prev <= 1'b0;
            from_erro  <= 1'b0;
            falha      <= 1'b0;
            watchdog   <= '0;
        end else begin
            state      <= next_state;
            ligar_prev <= ligar;
            from_erro  <= (state == ERRO);
            if (state == PREPARACAO) begin
                falha <= 1'b0;
            end else if (state == ERRO) begin
                falha <= 1'b1;
            end
            if (state == ESPERA_MEDIDA) begin
                watchdog <= watchdog + 1'b1;
            end else begin
                watchdog <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INICIAL: begin
                if (ligar_rise) begin
                    next_state = PREPARACAO;
                end
            end
            PREPARACAO: begin
                next_state = ESPERA_INTERVALO;
            end
            ESPERA_INTERVALO: begin
                if (fim_contador_intervalo) begin
                    next_state = MEDIDA;
                end
            end
            MEDIDA: begin
                next_state = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                // A late echo arriving on the expiry cycle still counts.
                if (fim_distancia) begin
                    next_state = TRANSMISSAO;
                end else if (wd_expired) begin
                    next_state = ERRO;
                end
            end
            TRANSMISSAO: begin
                next_state = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (fim_transmissao) begin
                    if (fim_contador_serial) begin
                        next_state = AJUSTA_SERVO;
                    end else begin
                        next_state = PROXIMO_CHAR;
                    end
                end
            end
            PROXIMO_CHAR: begin
                next_state = TRANSMISSAO;
            end
            AJUSTA_SERVO: begin
                if (!modo && ligar) begin
                    next_state = ESPERA_INTERVALO;
                end else begin
                    next_state = FINAL;
                end
            end
            ERRO: begin
                next_state = AJUSTA_SERVO;
            end
            FINAL: begin
                next_state = INICIAL;
            end
            default: begin
                next_state = INICIAL;
            end
        endcase
    end

    always_comb begin
        zera            = 1'b0;
        zera_pwm        = 1'b0;
        reset_updown    = 1'b0;
        conta_updown    = 1'b0;
        conta_intervalo = 1'b0;
        medir           = 1'b0;
        conta_serial    = 1'b0;
        transmitir      = 1'b0;
        pronto          = 1'b0;
        case (state)
            INICIAL: begin
                zera_pwm = 1'b1;
            end
            PREPARACAO: begin
                zera         = 1'b1;
                reset_updown = 1'b1;
                zera_pwm     = 1'b1;
            end
            ESPERA_INTERVALO: begin
                conta_intervalo = 1'b1;
            end
            MEDIDA: begin
                medir = 1'b1;
            end
            TRANSMISSAO: begin
                transmitir = 1'b1;
            end
            PROXIMO_CHAR: begin
                conta_serial = 1'b1;
            end
            AJUSTA_SERVO: begin
                conta_updown = 1'b1;
                conta_serial = ~from_erro;
            end
            FINAL: begin
                pronto = 1'b1;
            end
            default: begin
                zera = 1'b0;
            end
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Bench for sonar_sweep_uc: a behavioural datapath model answers the control
// unit, and each scenario compares observed pulse counts/states to expectations.
module tb_sonar_sweep_uc;

    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       modo = 1'b0;
    logic       fim_distancia = 1'b0;
    logic       fim_transmissao = 1'b0;
    logic       fim_contador_serial = 1'b0;
    logic       fim_contador_intervalo = 1'b0;
    logic       zera, zera_pwm, reset_updown, conta_updown, conta_intervalo;
    logic       medir, conta_serial, transmitir, pronto, falha;
    logic [3:0] db_estado;

    sonar_sweep_uc #(.TIMEOUT(TO), .TW(8)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
        .fim_distancia(fim_distancia), .fim_transmissao(fim_transmissao),
        .fim_contador_serial(fim_contador_serial),
        .fim_contador_intervalo(fim_contador_intervalo),
        .zera(zera), .zera_pwm(zera_pwm), .reset_updown(reset_updown),
        .conta_updown(conta_updown), .conta_intervalo(conta_intervalo),
        .medir(medir), .conta_serial(conta_serial), .transmitir(transmitir),
        .pronto(pronto), .falha(falha), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;

    int cyc = 0, n_medir = 0, n_tx = 0, n_prox = 0, n_cu = 0, n_cu_cs = 0;
    int n_pronto = 0, n_erro = 0, n_viol = 0, n_bad_medir = 0;
    int em_entry = 0, erro_lat = -1;
    int tx_q[$];
    logic [4:0] prev_pulses = '0;
    logic [3:0] prev_st = '0;
    bit seen_intv = 0;

    int idx = 0, icnt = 0, tx_cnt = 0, echo_cnt = 0;
    int intv_len = 3;
    int skip_at = 0, fixed_at = 0;

    // Observation plus datapath model (counters, UART and echo responders).
    always @(negedge clock) begin
        logic [4:0] pulses;
        cyc++;
        if (medir) begin
            n_medir++;
            if (!seen_intv) n_bad_medir++;
            seen_intv = 0;
        end
        if (db_estado == 4'b0010) seen_intv = 1;
        if (transmitir) begin
            n_tx++;
            tx_q.push_back(idx);
        end
        if (conta_serial && db_estado == 4'b0111) n_prox++;
        if (conta_updown) begin
            n_cu++;
            if (conta_serial) n_cu_cs++;
        end
        if (pronto) n_pronto++;
        if (db_estado == 4'b0100 && prev_st != 4'b0100) em_entry = cyc;
        if (db_estado == 4'b1110 && prev_st != 4'b1110) begin
            n_erro++;
            erro_lat = cyc - em_entry;
        end
        pulses = {medir, transmitir, conta_serial, conta_updown, pronto};
        if ((pulses & prev_pulses) != 5'b0) n_viol++;
        prev_pulses = pulses;
        prev_st = db_estado;

        fim_distancia = 1'b0;
        fim_transmissao = 1'b0;
        fim_contador_intervalo = 1'b0;
        if (zera) begin
            idx = 0; icnt = 0; tx_cnt = 0; echo_cnt = 0;
        end
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) fim_transmissao = 1'b1;
        end
        if (echo_cnt > 0) begin
            echo_cnt--;
            if (echo_cnt == 0) fim_distancia = 1'b1;
        end
        if (conta_intervalo) begin
            if (icnt == intv_len - 1) begin
                fim_contador_intervalo = 1'b1;
                icnt = 0;
            end else begin
                icnt++;
            end
        end
        if (conta_serial) idx = (idx + 1) % 8;
        if (transmitir) tx_cnt = $urandom_range(1, 6);
        if (medir) begin
            if (n_medir == skip_at) echo_cnt = 0;
            else if (n_medir == fixed_at) echo_cnt = TO;
            else echo_cnt = $urandom_range(1, TO - 1);
        end
        fim_contador_serial = (idx == 7);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_sweep(input logic m);
        modo = m;
        ligar = 1'b0;
        tick();
        ligar = 1'b1;
        tick();
        if (m) ligar = 1'b0;
    endtask

    task automatic wait_pronto(input int p0, input int budget, output bit ok);
        int n = 0;
        while (n_pronto == p0 && n < budget) begin
            tick();
            n++;
        end
        ok = (n_pronto != p0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ligar = 1'b1;
        modo = 1'b0;
        repeat (3) tick();
        checks++;
        if (db_estado !== 4'b0000) begin
            fails++; $display("FAIL reset_state: got %b expected 0000", db_estado);
        end
        checks++;
        if (zera_pwm !== 1'b1) begin
            fails++; $display("FAIL reset_zera_pwm: got %b expected 1", zera_pwm);
        end
        checks++;
        if ({zera, reset_updown, conta_updown, conta_intervalo, medir, conta_serial,
             transmitir, pronto, falha} !== 9'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected 000000000",
                {zera, reset_updown, conta_updown, conta_intervalo, medir, conta_serial,
                 transmitir, pronto, falha});
        end
        for (int i = 0; i < 4; i++) begin
            ligar = ~ligar;
            tick();
        end
        checks++;
        if (db_estado !== 4'b0000) begin
            fails++; $display("FAIL reset_no_start: got %b expected 0000", db_estado);
        end
        ligar = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (db_estado !== 4'b0000 || zera_pwm !== 1'b1) begin
            fails++; $display("FAIL idle_after_reset: got state %b zera_pwm %b expected 0000 1",
                db_estado, zera_pwm);
        end
    endtask

    task automatic test_single();
        int m0 = n_medir, t0 = n_tx, p0 = n_prox, c0 = n_cu, cc0 = n_cu_cs;
        int r0 = n_pronto, e0 = n_erro, bad = 0;
        bit ok;
        intv_len = $urandom_range(1, 5);
        start_sweep(1'b1);
        wait_pronto(r0, 3000, ok);
        checks++;
        if (!ok) begin
            fails++; $display("FAIL single_pronto: got 0 pronto expected 1 within budget");
        end
        tick();
        checks++;
        if (db_estado !== 4'b0000) begin
            fails++; $display("FAIL single_idle: got %b expected 0000", db_estado);
        end
        checks++;
        if (n_medir - m0 != 1 || n_tx - t0 != 8 || n_prox - p0 != 7) begin
            fails++; $display("FAIL single_counts: got medir %0d tx %0d prox %0d expected 1 8 7",
                n_medir - m0, n_tx - t0, n_prox - p0);
        end
        checks++;
        if (n_cu - c0 != 1 || n_cu_cs - cc0 != 1 || n_pronto - r0 != 1) begin
            fails++; $display("FAIL single_servo: got cu %0d cu_cs %0d pronto %0d expected 1 1 1",
                n_cu - c0, n_cu_cs - cc0, n_pronto - r0);
        end
        for (int i = t0; i < n_tx; i++) if (tx_q[i] != (i - t0) % 8) bad++;
        checks++;
        if (bad != 0 || falha !== 1'b0 || n_erro != e0) begin
            fails++; $display("FAIL single_frame: got bad_idx %0d falha %b erro %0d expected 0 0 0",
                bad, falha, n_erro - e0);
        end
    endtask

    task automatic test_continuous();
        int m0 = n_medir, t0 = n_tx, p0 = n_prox, c0 = n_cu, cc0 = n_cu_cs;
        int r0 = n_pronto, b0 = n_bad_medir, bad = 0, n = 0;
        bit ok;
        intv_len = $urandom_range(1, 5);
        start_sweep(1'b0);
        while (n_medir - m0 < 16 && n < 8000) begin
            tick();
            n++;
        end
        ligar = 1'b0;
        wait_pronto(r0, 3000, ok);
        checks++;
        if (!ok) begin
            fails++; $display("FAIL cont_pronto: got 0 pronto expected 1 within budget");
        end
        checks++;
        if (n_medir - m0 != 16 || n_tx - t0 != 128 || n_prox - p0 != 112) begin
            fails++; $display("FAIL cont_counts: got medir %0d tx %0d prox %0d expected 16 128 112",
                n_medir - m0, n_tx - t0, n_prox - p0);
        end
        checks++;
        if (n_cu - c0 != 16 || n_cu_cs - cc0 != 16 || n_pronto - r0 != 1) begin
            fails++; $display("FAIL cont_servo: got cu %0d cu_cs %0d pronto %0d expected 16 16 1",
                n_cu - c0, n_cu_cs - cc0, n_pronto - r0);
        end
        for (int i = t0; i < n_tx; i++) if (tx_q[i] != (i - t0) % 8) bad++;
        checks++;
        if (bad != 0 || n_bad_medir != b0) begin
            fails++; $display("FAIL cont_frames: got bad_idx %0d medir_without_interval %0d expected 0 0",
                bad, n_bad_medir - b0);
        end
    endtask

    task automatic test_stop_mid_frame();
        int m0 = n_medir, t0 = n_tx, r0 = n_pronto, n = 0;
        bit ok;
        start_sweep(1'b0);
        while (n_tx - t0 < 36 && n < 5000) begin
            tick();
            n++;
        end
        ligar = 1'b0;
        wait_pronto(r0, 2000, ok);
        checks++;
        if (!ok || n_tx - t0 != 40 || n_medir - m0 != 5) begin
            fails++; $display("FAIL stop_frame5: got pronto %b tx %0d medir %0d expected 1 40 5",
                ok, n_tx - t0, n_medir - m0);
        end
        repeat (100) tick();
        checks++;
        if (n_medir - m0 != 5 || db_estado !== 4'b0000) begin
            fails++; $display("FAIL stop_quiet: got medir %0d state %b expected 5 0000",
                n_medir - m0, db_estado);
        end
    endtask

    task automatic test_timeout();
        int m0 = n_medir, t0 = n_tx, c0 = n_cu, cc0 = n_cu_cs, r0 = n_pronto;
        int n = 0, bad = 0, t1;
        bit ok;
        skip_at = n_medir + 1;
        start_sweep(1'b0);
        while (db_estado !== 4'b1110 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (db_estado !== 4'b1110 || erro_lat != TO || n_tx != t0) begin
            fails++; $display("FAIL timeout_erro: got state %b latency %0d tx %0d expected 1110 %0d 0",
                db_estado, erro_lat, n_tx - t0, TO);
        end
        tick();
        checks++;
        if (db_estado !== 4'b1000 || conta_updown !== 1'b1 || conta_serial !== 1'b0 || falha !== 1'b1) begin
            fails++; $display("FAIL timeout_ajusta: got state %b cu %b cs %b falha %b expected 1000 1 0 1",
                db_estado, conta_updown, conta_serial, falha);
        end
        t1 = n_tx;
        n = 0;
        while (n_medir - m0 < 2 && n < 1000) begin
            tick();
            n++;
        end
        ligar = 1'b0;
        wait_pronto(r0, 2000, ok);
        for (int i = t1; i < n_tx; i++) if (tx_q[i] != (i - t1) % 8) bad++;
        checks++;
        if (!ok || n_tx - t0 != 8 || bad != 0) begin
            fails++; $display("FAIL timeout_next_frame: got pronto %b tx %0d bad_idx %0d expected 1 8 0",
                ok, n_tx - t0, bad);
        end
        checks++;
        if (n_cu - c0 != 2 || n_cu_cs - cc0 != 1) begin
            fails++; $display("FAIL timeout_servo: got cu %0d cu_cs %0d expected 2 1",
                n_cu - c0, n_cu_cs - cc0);
        end
        repeat (3) tick();
        checks++;
        if (falha !== 1'b1 || db_estado !== 4'b0000) begin
            fails++; $display("FAIL timeout_sticky: got falha %b state %b expected 1 0000",
                falha, db_estado);
        end
    endtask

    task automatic test_tie();
        int t0 = n_tx, e0 = n_erro, r0 = n_pronto;
        bit ok;
        fixed_at = n_medir + 1;
        start_sweep(1'b1);
        wait_pronto(r0, 2000, ok);
        checks++;
        if (!ok || falha !== 1'b0 || n_erro != e0 || n_tx - t0 != 8) begin
            fails++; $display("FAIL tie_echo_wins: got pronto %b falha %b erro %0d tx %0d expected 1 0 0 8",
                ok, falha, n_erro - e0, n_tx - t0);
        end
    endtask

    task automatic test_async_reset();
        int t0 = n_tx, n = 0, bad = 0, t1, r1;
        bit ok;
        skip_at = n_medir + 1;
        start_sweep(1'b0);
        while (!(n_tx - t0 >= 5 && db_estado == 4'b0110) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (db_estado !== 4'b0110 || falha !== 1'b1) begin
            fails++; $display("FAIL areset_setup: got state %b falha %b expected 0110 1",
                db_estado, falha);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 4'b0000 || falha !== 1'b0 || zera_pwm !== 1'b1) begin
            fails++; $display("FAIL areset_immediate: got state %b falha %b zera_pwm %b expected 0000 0 1",
                db_estado, falha, zera_pwm);
        end
        ligar = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        t1 = n_tx;
        r1 = n_pronto;
        start_sweep(1'b1);
        wait_pronto(r1, 2000, ok);
        for (int i = t1; i < n_tx; i++) if (tx_q[i] != (i - t1) % 8) bad++;
        checks++;
        if (!ok || n_tx - t1 != 8 || bad != 0) begin
            fails++; $display("FAIL areset_restart: got pronto %b tx %0d bad_idx %0d expected 1 8 0",
                ok, n_tx - t1, bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_stop_mid_frame();
        test_timeout();
        test_tie();
        test_async_reset();
        checks++;
        if (n_viol != 0 || n_bad_medir != 0) begin
            fails++; $display("FAIL pulse_width: got double_pulses %0d medir_without_interval %0d expected 0 0",
                n_viol, n_bad_medir);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sonar_sweep_uc.md
Name: sonar_sweep_uc

Overview:
Control unit that sequences the sonar datapath. It steps the servo through 8 positions, waits for the servo to settle at each one, and triggers one HC-SR04 measurement per position. It then serialises an 8-character frame (angle, ',', distance, '#') through the 7O1 transmitter. It instantiates in the sonar top beside the datapath and drives every datapath control input. It adds an echo watchdog so that a missing echo cannot hang the sweep.

Parameters:
TIMEOUT, 3_000_000, cycles allowed in ESPERA_MEDIDA before declaring echo failure (60 ms at 50 MHz)
TW, 22, width of internal watchdog counter (2^TW > TIMEOUT)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ligar  in  1  level; 1 = sweep enabled
modo  in  1  0 = continuous sweep, 1 = single position per ligar rising edge
fim_distancia  in  1  datapath measurement done pulse
fim_transmissao  in  1  datapath character transmitted pulse
fim_contador_serial  in  1  serial char counter at last index (7)
fim_contador_intervalo  in  1  settle-interval counter at terminal count
zera  out  1  synchronous clear of datapath counters/interfaces
zera_pwm  out  1  holds servo PWM generator in reset
reset_updown  out  1  clears servo position up/down counter
conta_updown  out  1  advance servo position
conta_intervalo  out  1  enable settle-interval counter
medir  out  1  start measurement pulse
conta_serial  out  1  advance serial char index
transmitir  out  1  start one-character transmission pulse
pronto  out  1  one-cycle pulse: frame (or single shot) complete
falha  out  1  sticky: at least one echo timeout since last start
db_estado  out  4  current state code

Behaviour:
- Moore FSM; outputs decoded from the state register only. falha is a separate flop. Watchdog counter is internal.
- State codes:
  - INICIAL 0000
  - PREPARACAO 0001
  - ESPERA_INTERVALO 0010
  - MEDIDA 0011
  - ESPERA_MEDIDA 0100
  - TRANSMISSAO 0101
  - ESPERA_TX 0110
  - PROXIMO_CHAR 0111
  - AJUSTA_SERVO 1000
  - FINAL 1001
  - ERRO 1110
  - Unused codes go to INICIAL.
- Reset (reset=0, async): state=INICIAL, falha=0, watchdog=0. In INICIAL, zera_pwm=1 and all other outputs are 0.
- ligar rising edge is detected with a registered previous value, which is cleared by reset.
- Transitions and outputs:
  - INICIAL: ligar rising edge -> PREPARACAO.
  - PREPARACAO: zera=1, reset_updown=1, zera_pwm=1; clears falha. -> ESPERA_INTERVALO next cycle.
  - ESPERA_INTERVALO: conta_intervalo=1. fim_contador_intervalo=1 -> MEDIDA. The counter wraps on the same edge.
  - MEDIDA: medir=1 for exactly one cycle. -> ESPERA_MEDIDA.
  - ESPERA_MEDIDA: watchdog is zeroed on entry and increments each cycle.
    - fim_distancia=1 -> TRANSMISSAO.
    - Watchdog = TIMEOUT-1 with fim_distancia=0 -> ERRO.
    - If both occur in the same cycle, fim_distancia wins.
  - TRANSMISSAO: transmitir=1 for one cycle. -> ESPERA_TX.
  - ESPERA_TX: wait for fim_transmissao.
    - Then fim_contador_serial=1 -> AJUSTA_SERVO, else -> PROXIMO_CHAR.
  - PROXIMO_CHAR: conta_serial=1 for one cycle. -> TRANSMISSAO.
  - AJUSTA_SERVO: conta_updown=1 and conta_serial=1 for one cycle. The serial index wraps 7->0 and the servo moves one step (up/down handled by the datapath).
    - modo=1 -> FINAL.
    - modo=0 and ligar=1 -> ESPERA_INTERVALO.
    - modo=0 and ligar=0 -> FINAL.
  - ERRO: falha<=1, one cycle. No frame is sent for this position. -> AJUSTA_SERVO, with serial index still 0. conta_serial is suppressed in this path: AJUSTA_SERVO entered from ERRO asserts conta_updown only.
  - FINAL: pronto=1 for one cycle. -> INICIAL.
- ligar falling mid-frame: the current frame always completes, and the stop is taken only at AJUSTA_SERVO. Only reset aborts mid-frame.
- Async reset mid-transmission returns to INICIAL immediately. The datapath is cleared by the next PREPARACAO.
- falha persists through FINAL/INICIAL until the next PREPARACAO or reset.
- All single-cycle outputs (medir, transmitir, conta_serial, conta_updown, pronto) are never high for 2 consecutive cycles.

Test Plan:
- Reset with ligar=1 held -> state 0000, zera_pwm=1, all other outputs 0. No start without a rising edge.
- modo=1, ligar pulse, echo model answers after 100 cycles, each fim_transmissao 50 cycles after transmitir:
  - medir pulses exactly once.
  - Exactly 8 transmitir pulses and 7 PROXIMO_CHAR conta_serial pulses.
  - One AJUSTA_SERVO with conta_updown=1 and conta_serial=1.
  - pronto once, then db_estado=0000.
- modo=0, ligar held through 16 positions:
  - 16 conta_updown pulses and 128 transmitir pulses.
  - ESPERA_INTERVALO is entered before every medir.
  - Drop ligar during char 3 of frame 5 -> frame 5 completes, pronto asserts, and no further medir.
- TIMEOUT=20, no fim_distancia -> ERRO (1110) entered exactly 20 cycles after ESPERA_MEDIDA entry:
  - falha=1.
  - No transmitir for that position.
  - conta_updown=1 with conta_serial=0.
  - Next position proceeds normally and falha stays 1 until the next start.
- fim_distancia asserted in the same cycle the watchdog hits TIMEOUT-1 -> goes to TRANSMISSAO, and falha stays 0.
- Assert reset=0 in ESPERA_TX of char 4 -> state 0000 asynchronously (before the next clock edge), falha=0. A restart sends a full 8-char frame from index 0.
